rf_bank_req_queue: RTL
======================

# rf_bank_req_queue

Per-bank read-request queue and arbiter between the register allocation/mapping stage and the 4-bank physical register file.
- Accepts up to two translated source-operand requests per cycle (bank, row, operand-collector tag) and buffers them in one FIFO per bank.
- Issues at most one read per bank per cycle; CDB writes to a bank take priority over its read.
- Returns each read's collector tag aligned with the bank's 1-cycle-latency read data.

## Interface
Parameters:
- DEPTH, 4, entries per bank FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- Valid_RAU_RFQ  in  1  instruction dispatched from mapping stage this cycle.
- Src1_Valid / Src2_Valid  in  1 each  operand needs a register read.
- Src1_Phy_Bank_ID / Src2_Phy_Bank_ID  in  2 each  physical bank.
- Src1_Phy_Row_ID / Src2_Phy_Row_ID  in  3 each  physical row.
- Src1_OCID / Src2_OCID  in  3 each  destination collector slot ({OC, operand}).
- ReqFIFO_2op_EN  in  1  both operands valid and target the same bank.
- ReqFIFO_Same  in  1  both operands name the same architectural register.
- WriteValid  in  1  CDB write this cycle.
- WriteBank  in  2  bank written.
- WriteRow  in  3  row written; informational only.
- Stall_RFQ_RAU  out  1  upstream must hold; reset 0.
- Read_EN  out  4  per-bank read strobe; reset 0.
- Read_Row  out  12  row for bank b at [3b+2:3b]; reset 0.
- RdTag_Valid  out  4  tag valid for bank b, one cycle after Read_EN[b]; reset 0.
- RdTag_OCID  out  12  collector slot for bank b at [3b+2:3b]; reset 0.
- RdTag_Dup  out  4  also deliver the bank b data to slot RdTag_OCID^1; reset 0.

## Operation
FIFO entry format: {row[2:0], ocid[2:0], dup}.
- Each bank has an occupancy counter of width log2(DEPTH)+1, plus wrapping read and write pointers.

Stall:
- Stall_RFQ_RAU = 1 when any bank's free count is < 2.
- It is combinational from registered counts only. It does not depend on same-cycle inputs or dequeues.

Enqueue happens only when Valid_RAU_RFQ=1 and Stall_RFQ_RAU=0. Cases, in priority order:
- Src1_Valid & Src2_Valid & ReqFIFO_Same: one entry {Src1_Phy_Row_ID, Src1_OCID, dup=1} into bank Src1_Phy_Bank_ID.
- Else ReqFIFO_2op_EN: two entries into the same bank, Src1 first, then Src2. The counter advances by 2 and the write pointer wraps modulo DEPTH.
- Else: each valid source is enqueued into its own bank with dup=0. Two different banks may be written in the same cycle.
- No valid source: nothing is enqueued.
- Inputs presented while stalled are ignored. Upstream re-presents them.

Dequeue, per bank b, every cycle:
- Condition: count_b ≠ 0 and not (WriteValid & WriteBank==b).
- When met: Read_EN[b]=1, Read_Row[b] = head row, head popped.
- Read_EN and Read_Row are registered outputs computed from the pre-edge FIFO head, so they are valid in the cycle after the decision.
- A write-blocked bank keeps its head; there is no other starvation mechanism.

Enqueue/dequeue interaction:
- Enqueue and dequeue on the same bank in the same cycle are both honoured: count += pushed − popped.
- There is no bypass. An entry pushed at edge N is eligible for dequeue at edge N+1 at the earliest.

Tag pipeline:
- RdTag_* for bank b are registered copies of the popped entry's ocid/dup, valid the cycle after Read_EN[b].
- This aligns them with the bank's read data.

Reset:
- rst=0 at any edge clears all counters, pointers, Read_EN, RdTag_Valid, RdTag_OCID, RdTag_Dup and Read_Row.
- In-flight requests are discarded.

## Timing
- Cycle N: a valid request is accepted and enters the FIFO at edge N.
- Cycle N+1: Read_EN[b]=1 if the bank is unblocked and the entry is at the head (best-case latency 1).
- Cycle N+2: RdTag_Valid[b]=1 with OCID/Dup.
- Throughput: one read per bank per cycle; 4 reads per cycle aggregate.
- Stall reflects the counts after edge N. A request accepted at N can raise stall in N+1.
- A write to bank b in cycle k suppresses Read_EN[b] for cycle k+1 only.
- Full boundary: with count=DEPTH−1, stall=1. A same-cycle pop does not release stall until the next cycle.
- Wrap-around: pointers wrap modulo DEPTH. Two-entry pushes straddle the wrap correctly.

## Test plan
1. Reset, then Src1 {bank2, row5, OCID 0} valid, Src2 invalid → cycle 1: Read_EN=0100, Read_Row[8:6]=5; cycle 2: RdTag_Valid=0100, RdTag_OCID[8:6]=0, Dup=0.
2. Same-bank pair: bank1 rows 3 and 6, OCID 2 and 3 → reads on bank1 in cycles 1 and 2 (rows 3, then 6); tags 2, then 3.
3. ReqFIFO_Same on bank0 row 4, OCID 4 → a single read; RdTag_OCID=4, RdTag_Dup[0]=1; no second read.
4. Bank3 holds an entry while WriteValid=1, WriteBank=3 for 2 cycles → Read_EN[3]=0 during the block; the read issues the cycle after the write ends; the other banks are unaffected.
5. Six same-bank pairs to bank0 back-to-back, DEPTH=4 → stall asserts once free<2; no entry lost or duplicated; reads return in issue order across wrap-around; stall deasserts after draining.
6. Assert rst=0 with entries queued in all banks → next cycle all outputs 0 and counts 0; no stale reads after rst=1.

Source files
------------

// File: rtl/rf_bank_req_queue.sv
// Per-bank read-request FIFOs feeding the 4-bank physical register file.
// Each bank issues at most one read per cycle, yields to CDB writes, and returns tags aligned with read data.
module rf_bank_req_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Valid_RAU_RFQ,
  input  logic        Src1_Valid,
  input  logic        Src2_Valid,
  input  logic [1:0]  Src1_Phy_Bank_ID,
  input  logic [1:0]  Src2_Phy_Bank_ID,
  input  logic [2:0]  Src1_Phy_Row_ID,
  input  logic [2:0]  Src2_Phy_Row_ID,
  input  logic [2:0]  Src1_OCID,
  input  logic [2:0]  Src2_OCID,
  input  logic        ReqFIFO_2op_EN,
  input  logic        ReqFIFO_Same,
  input  logic        WriteValid,
  input  logic [1:0]  WriteBank,
  input  logic [2:0]  WriteRow,
  output logic        Stall_RFQ_RAU,
  output logic [3:0]  Read_EN,
  output logic [11:0] Read_Row,
  output logic [3:0]  RdTag_Valid,
  output logic [11:0] RdTag_OCID,
  output logic [3:0]  RdTag_Dup
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // entry layout: {row[2:0], ocid[2:0], dup}
  logic [6:0]    r_mem [4][DEPTH];
  logic [PW-1:0] r_wp [4];
  logic [PW-1:0] r_rp [4];
  logic [CW-1:0] r_cnt [4];
  logic [2:0]    r_pop_oc [4];
  logic [3:0]    r_pop_dup;

  logic [1:0]    w_n [4];
  logic [6:0]    w_d0 [4];
  logic [6:0]    w_d1 [4];
  logic [PW-1:0] w_wp1 [4];
  logic [3:0]    w_pop;
  logic          w_stall;
  logic          w_accept;
  logic [6:0]    w_e1;
  logic [6:0]    w_e2;
  logic          w_unused_write_row;

  // WriteRow only identifies the written row; arbitration is per bank
  assign w_unused_write_row = ^WriteRow;

  always_comb begin
    w_stall = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (r_cnt[b] >= CW'(DEPTH - 1)) w_stall = 1'b1;
    end
  end

  assign Stall_RFQ_RAU = w_stall;
  assign w_accept      = Valid_RAU_RFQ & ~w_stall;
  assign w_e1          = {Src1_Phy_Row_ID, Src1_OCID, 1'b0};
  assign w_e2          = {Src2_Phy_Row_ID, Src2_OCID, 1'b0};

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_n[b]   = 2'd0;
      w_d0[b]  = 7'd0;
      w_d1[b]  = 7'd0;
      w_wp1[b] = r_wp[b] + PW'(1);
      w_pop[b] = (r_cnt[b] != '0) && !(WriteValid && (WriteBank == 2'(b)));
      if (w_accept) begin
        if (Src1_Valid && Src2_Valid && ReqFIFO_Same) begin
          if (Src1_Phy_Bank_ID == 2'(b)) begin
            w_n[b]  = 2'd1;
            w_d0[b] = {Src1_Phy_Row_ID, Src1_OCID, 1'b1};
          end
        end else if (ReqFIFO_2op_EN) begin
          if (Src1_Phy_Bank_ID == 2'(b)) begin
            w_n[b]  = 2'd2;
            w_d0[b] = w_e1;
            w_d1[b] = w_e2;
          end
        end else begin
          if (Src1_Valid && (Src1_Phy_Bank_ID == 2'(b))) begin
            w_n[b]  = 2'd1;
            w_d0[b] = w_e1;
          end
          if (Src2_Valid && (Src2_Phy_Bank_ID == 2'(b))) begin
            if (w_n[b] == 2'd1) begin
              w_n[b]  = 2'd2;
              w_d1[b] = w_e2;
            end else begin
              w_n[b]  = 2'd1;
              w_d0[b] = w_e2;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        r_wp[b]     <= '0;
        r_rp[b]     <= '0;
        r_cnt[b]    <= '0;
        r_pop_oc[b] <= 3'd0;
      end
      r_pop_dup   <= 4'd0;
      Read_EN     <= 4'd0;
      Read_Row    <= 12'd0;
      RdTag_Valid <= 4'd0;
      RdTag_OCID  <= 12'd0;
      RdTag_Dup   <= 4'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_n[b] != 2'd0) r_mem[b][r_wp[b]] <= w_d0[b];
        if (w_n[b] == 2'd2) r_mem[b][w_wp1[b]] <= w_d1[b];
        r_wp[b]  <= r_wp[b] + PW'(w_n[b]);
        r_cnt[b] <= r_cnt[b] + CW'(w_n[b]) - CW'(w_pop[b]);
        Read_EN[b] <= w_pop[b];
        if (w_pop[b]) begin
          r_rp[b]             <= r_rp[b] + PW'(1);
          Read_Row[3*b +: 3]  <= r_mem[b][r_rp[b]][6:4];
          r_pop_oc[b]         <= r_mem[b][r_rp[b]][3:1];
          r_pop_dup[b]        <= r_mem[b][r_rp[b]][0];
        end
        // tag stage trails Read_EN by one cycle to line up with bank data
        RdTag_Valid[b] <= Read_EN[b];
        if (Read_EN[b]) begin
          RdTag_OCID[3*b +: 3] <= r_pop_oc[b];
          RdTag_Dup[b]         <= r_pop_dup[b];
        end
      end
    end
  end

endmodule
